lsu_mem_adapter: RTL and testbench
==================================

Name: lsu_mem_adapter

Overview:
- Load/store unit between the core's execute stage and the word-only data memory.
- Converts RV32I byte addresses and funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-indexed memory accesses.
- Sign- or zero-extends load data.
- Implements sub-word stores as read-modify-write. The memory has no byte enables and returns zero on RD while WE=1, so the read and the write occupy separate cycles.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory; valid word index 0..DEPTH-1.
- IDX_W, 10, width of the word index (clog2(DEPTH)).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core presents a load/store request
- req_ready  output  1  adapter can accept a request this cycle
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I load/store funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- resp_valid  output  1  one-cycle pulse: request completed
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  qualified by resp_valid: misaligned, out-of-range or illegal funct3
- mem_A  output  32  word index to data memory, zero-extended
- mem_WE  output  1  data memory write enable
- mem_WD  output  32  data memory write data
- mem_RD  input  32  data memory combinational read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_A=0, mem_WE=0, mem_WD=0.
  - All latched request fields cleared. mem_WE must drop immediately, not at the next edge.
- Handshake: a request is accepted on a rising edge with req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE.
  - While busy the core must hold its request; inputs are ignored.
- On accept, latch the request fields:
  - widx = req_addr[IDX_W+1:2]
  - off = req_addr[1:0]
  - funct3, we and wdata
- Error classification, evaluated on accept:
  - misaligned: H-type with off[0]=1, or W-type with off!=0.
  - out-of-range: req_addr[31:2] >= DEPTH.
  - illegal funct3:
    - loads: 011, 110, 111.
    - stores: any value other than 000, 001, 010.
  - Any error -> ERR.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, ERR.
  - IDLE -> LOAD (valid load), RMW_RD (SB/SH), WRITE (SW), ERR (error).
  - LOAD: mem_A=widx, mem_WE=0. At the edge, resp_rdata is registered from mem_RD per off/funct3 with sign or zero extension; resp_valid=1 next cycle; -> IDLE.
  - RMW_RD: mem_A=widx, mem_WE=0. At the edge, merge register = mem_RD with lane(s) at off replaced by wdata[7:0] or wdata[15:0]; -> WRITE.
  - WRITE: mem_A=widx, mem_WE=1, mem_WD = merge register (SB/SH) or wdata (SW). The memory writes on this edge; resp_valid=1 next cycle with resp_rdata=0; -> IDLE.
  - ERR: no memory access (mem_WE stays 0); resp_valid=1, resp_err=1 next cycle; -> IDLE.
- Latency, counted from the accept edge to the resp_valid cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 2 cycles
- Back-to-back: req_ready is combinational from state, so a new request can be accepted in the same cycle resp_valid is high. resp_valid never exceeds one cycle per request.
- Memory-side outputs:
  - mem_WE=1 only in WRITE.
  - mem_WD=0 outside WRITE.
  - mem_A holds the last latched widx.
- Byte lanes are little-endian: byte k = word[8k+7:8k]; half at off=2 = word[31:16].
- Reset mid-operation (any state): the request is dropped, no resp_valid is issued, and memory is not written unless the WRITE edge already occurred.

Test Plan:
- Preload word 25 = 0x12345678; LB addr 0x65 -> resp_rdata=0x00000056, resp_err=0, resp_valid 2 cycles after accept.
- Preload word 25 = 0x80FF5678:
  - LH addr 0x66 -> 0xFFFF80FF
  - LHU addr 0x66 -> 0x000080FF
  - LBU addr 0x67 -> 0x00000080
- Preload word 25 = 0x12345678; SB wdata=0xAB, addr 0x66 -> one RMW_RD cycle with mem_WE=0, then mem_WE=1 with mem_WD=0x12AB5678; resp_valid on the third cycle; a subsequent LW addr 0x64 returns 0x12AB5678.
- SH addr 0x67 and LW addr 0x1000 (word 1024) -> resp_err=1, resp_rdata=0, mem_WE never asserted, latency 2.
- SW 0xFFFFFFFF addr 0xB4 (word 45), immediately followed by LW 0xB4 accepted in the resp cycle -> second resp_rdata=0xFFFFFFFF and req_ready=1 in both resp cycles.
- Assert rst_n=0 asynchronously during RMW_RD of SB 0x55 to addr 0x64 -> mem_WE=0 and req_ready=1 immediately, no resp_valid, word 25 unchanged.

Source files
------------

// File: rtl/lsu_mem_adapter.sv
// RV32I load/store adapter onto a word-only data memory without byte enables.
// Sub-word stores become a read cycle followed by a separate write cycle.
module lsu_mem_adapter #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_A,
   output logic        mem_WE,
   output logic [31:0] mem_WD,
   input  logic [31:0] mem_RD
);

   typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, ERR} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  widx_q;
   logic [1:0]        off_q;
   logic [2:0]        funct3_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merge_q, merge_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

   logic              accept, illegal, misal, oor, req_bad;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       load_ext;

   assign req_ready  = (state_q == IDLE);
   assign accept     = req_valid && req_ready;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   // Memory-side outputs decode straight from state so reset kills mem_WE at once.
   assign mem_A  = {{(32-IDX_W){1'b0}}, widx_q};
   assign mem_WE = (state_q == WRITE);
   assign mem_WD = (state_q != WRITE)      ? 32'd0 :
                   (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;

   always_comb begin
      illegal = req_we ? !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010)
                       :  (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
      misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      oor     = (req_addr[31:2] >= 30'(DEPTH));
      req_bad = illegal || misal || oor;
   end

   always_comb begin
      byte_sel = mem_RD[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? mem_RD[31:16] : mem_RD[15:0];
      case (funct3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = mem_RD;
      endcase
   end

   always_comb begin
      merge_d = mem_RD;
      if (funct3_q[1:0] == 2'b00)
         merge_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         merge_d[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = 32'd0;
      resp_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_bad)                       state_d = ERR;
               else if (!req_we)                  state_d = LOAD;
               else if (req_funct3[1:0] == 2'b10) state_d = WRITE;
               else                               state_d = RMW_RD;
            end
         end
         LOAD: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
         end
         RMW_RD: state_d = WRITE;
         WRITE: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
         end
         ERR: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         widx_q       <= '0;
         off_q        <= '0;
         funct3_q     <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         merge_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         if (accept) begin
            widx_q   <= req_addr[IDX_W+1:2];
            off_q    <= req_addr[1:0];
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
         end
         if (state_q == RMW_RD)
            merge_q <= merge_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter with a behavioural word memory behind it.
module tb_lsu_mem_adapter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_A, mem_WD, mem_RD;
   logic        mem_WE;

   logic [31:0] mem [0:1023];
   logic        pl_en;
   logic [9:0]  pl_idx;
   logic [31:0] pl_val;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign mem_RD = mem_WE ? 32'd0 : mem[mem_A[9:0]];
   always @(posedge clk) begin
      if (mem_WE)     mem[mem_A[9:0]] <= mem_WD;
      else if (pl_en) mem[pl_idx]     <= pl_val;
   end

   lsu_mem_adapter #(.DEPTH(1024), .IDX_W(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
   );

   task automatic preload(input logic [9:0] idx, input logic [31:0] val);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_val = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Drives one request and follows it to its response; lat counts the accept cycle as 1.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output logic saw_we, output logic we_first,
                         output logic [31:0] wd_seen, output logic rdy_resp);
      int guard;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      guard = 0;
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      we_first = mem_WE;
      saw_we = mem_WE;
      wd_seen = mem_WE ? mem_WD : 32'd0;
      while (!resp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
         if (mem_WE) begin saw_we = 1'b1; wd_seen = mem_WD; end
      end
      rd = resp_rdata; er = resp_err; rdy_resp = req_ready;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0 ||
          mem_A !== 32'd0 || mem_WE !== 1'b0 || mem_WD !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: rdy=%b rv=%b err=%b rd=%h A=%h WE=%b WD=%h (want 1 0 0 0 0 0 0)",
                  req_ready, resp_valid, resp_err, resp_rdata, mem_A, mem_WE, mem_WD);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_loads();
      int lat; logic [31:0] rd, wds; logic er, sw, wf, rr;
      logic [2:0]  f3 [4]  = '{3'b000, 3'b001, 3'b101, 3'b100};
      logic [31:0] ad [4]  = '{32'h65, 32'h66, 32'h66, 32'h67};
      logic [31:0] ex [4]  = '{32'h00000056, 32'hFFFF80FF, 32'h000080FF, 32'h00000080};
      logic [31:0] pv [4]  = '{32'h12345678, 32'h80FF5678, 32'h80FF5678, 32'h80FF5678};
      for (int i = 0; i < 4; i++) begin
         preload(10'd25, pv[i]);
         do_req(1'b0, f3[i], ad[i], 32'h0, lat, rd, er, sw, wf, wds, rr);
         checks++;
         if (rd !== ex[i] || er !== 1'b0 || lat != 2 || sw !== 1'b0) begin
            failures++;
            $display("FAIL load_%0d: rdata=%h err=%b lat=%0d we=%b want %h 0 2 0", i, rd, er, lat, sw, ex[i]);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL resp_pulse_width: resp_valid=%b want 0", resp_valid);
      end
   endtask

   task automatic test_sb_rmw();
      int lat; logic [31:0] rd, wds; logic er, sw, wf, rr;
      preload(10'd25, 32'h12345678);
      do_req(1'b1, 3'b000, 32'h66, 32'h000000AB, lat, rd, er, sw, wf, wds, rr);
      checks++;
      if (wf !== 1'b0 || sw !== 1'b1 || wds !== 32'h12AB5678) begin
         failures++;
         $display("FAIL sb_rmw_write: we_rd_cycle=%b we_seen=%b wd=%h want 0 1 12ab5678", wf, sw, wds);
      end
      checks++;
      if (lat != 3 || rd !== 32'd0 || er !== 1'b0) begin
         failures++;
         $display("FAIL sb_resp: lat=%0d rdata=%h err=%b want 3 0 0", lat, rd, er);
      end
      do_req(1'b0, 3'b010, 32'h64, 32'h0, lat, rd, er, sw, wf, wds, rr);
      checks++;
      if (rd !== 32'h12AB5678 || lat != 2) begin
         failures++;
         $display("FAIL sb_readback: rdata=%h lat=%0d want 12ab5678 2", rd, lat);
      end
      preload(10'd26, 32'hCAFEF00D);
      do_req(1'b1, 3'b001, 32'h6A, 32'h0000BEEF, lat, rd, er, sw, wf, wds, rr);
      checks++;
      if (wds !== 32'hBEEFF00D || lat != 3 || mem[26] !== 32'hBEEFF00D) begin
         failures++;
         $display("FAIL sh_upper: wd=%h lat=%0d mem=%h want beeff00d 3 beeff00d", wds, lat, mem[26]);
      end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd, wds; logic er, sw, wf, rr;
      logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0]  f3 [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
      logic [31:0] ad [4] = '{32'h67, 32'h1000, 32'h64, 32'h64};
      preload(10'd25, 32'h11223344);
      for (int i = 0; i < 4; i++) begin
         do_req(we[i], f3[i], ad[i], 32'hDEADBEEF, lat, rd, er, sw, wf, wds, rr);
         checks++;
         if (er !== 1'b1 || rd !== 32'd0 || sw !== 1'b0 || lat != 2) begin
            failures++;
            $display("FAIL err_%0d: err=%b rdata=%h we=%b lat=%0d want 1 0 0 2", i, er, rd, sw, lat);
         end
      end
      checks++;
      if (mem[25] !== 32'h11223344) begin
         failures++;
         $display("FAIL err_no_write: word25=%h want 11223344", mem[25]);
      end
      do_req(1'b0, 3'b010, 32'hFFC, 32'h0, lat, rd, er, sw, wf, wds, rr);
      checks++;
      if (er !== 1'b0 || lat != 2) begin
         failures++;
         $display("FAIL last_word_ok: err=%b lat=%0d want 0 2", er, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] rd, wds; logic er, sw, wf, rr;
      preload(10'd45, 32'h0);
      do_req(1'b1, 3'b010, 32'hB4, 32'hFFFFFFFF, lat, rd, er, sw, wf, wds, rr);
      checks++;
      if (lat != 2 || rr !== 1'b1 || wds !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL b2b_sw: lat=%0d ready=%b wd=%h want 2 1 ffffffff", lat, rr, wds);
      end
      do_req(1'b0, 3'b010, 32'hB4, 32'h0, lat, rd, er, sw, wf, wds, rr);
      checks++;
      if (rd !== 32'hFFFFFFFF || lat != 2 || rr !== 1'b1 || er !== 1'b0) begin
         failures++;
         $display("FAIL b2b_lw: rdata=%h lat=%0d ready=%b err=%b want ffffffff 2 1 0", rd, lat, rr, er);
      end
   endtask

   task automatic test_reset_mid();
      int rv_seen, we_seen;
      preload(10'd25, 32'h12345678);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h64; req_wdata = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_WE !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_now: WE=%b ready=%b rv=%b want 0 1 0", mem_WE, req_ready, resp_valid);
      end
      @(negedge clk); rst_n = 1'b1;
      rv_seen = 0; we_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (resp_valid) rv_seen++;
         if (mem_WE) we_seen++;
      end
      checks++;
      if (rv_seen != 0 || we_seen != 0 || mem[25] !== 32'h12345678) begin
         failures++;
         $display("FAIL reset_mid_after: resp=%0d we=%0d word25=%h want 0 0 12345678",
                  rv_seen, we_seen, mem[25]);
      end
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
      pl_en = 1'b0; pl_idx = '0; pl_val = '0;
      test_reset();
      test_loads();
      test_sb_rmw();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
